// File: rtl/shading_pkg.sv
// shading_pkg: shared Q8.24 vector types, shading constants and fixed-point multiply helper
package shading_pkg;
   localparam int FRAC_BITS = 24;
   localparam int PROD_W = 40;
   localparam int DOT_W = 42;
   typedef logic signed [31:0] fp;
   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;
   localparam fp AMB_BASE = 32'sd1677721;
   localparam fp AMB_SKY = 32'sd1677721;
   localparam fp DIFF_K = 32'sd13421772;
   function automatic vec3 make_vec3(fp x, fp y, fp z);
      return {x, y, z};
   endfunction
   // full 64-bit signed product, floor-shifted back to Q8.24 scale
   function automatic logic signed [PROD_W-1:0] fmul(fp a, fp b);
      logic signed [63:0] p;
      p = 64'(a) * 64'(b);
      return PROD_W'(p >>> FRAC_BITS);
   endfunction
endpackage

// File: rtl/shading_if.sv
// shading_if: sample/result bus; master drives samples (valid_in, hit_in, normal_vec, light_vec), slave returns shade_out/valid_out
interface shading_if #(parameter int OUT_WIDTH = 24);
   logic valid_in;
   logic hit_in;
   shading_pkg::vec3 normal_vec;
   shading_pkg::vec3 light_vec;
   logic [OUT_WIDTH-1:0] shade_out;
   logic valid_out;
   modport master (output valid_in, hit_in, normal_vec, light_vec, input shade_out, valid_out);
   modport slave (input valid_in, hit_in, normal_vec, light_vec, output shade_out, valid_out);
endinterface

// File: rtl/shading_vec3_dot.sv
// vec3_dot: registered Q8.24 per-axis products (i_en loads) with combinational sum o_dot; ports clk, rst_n, i_en, i_a, i_b, o_dot
module vec3_dot
   import shading_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_en,
   input  vec3                     i_a,
   input  vec3                     i_b,
   output logic signed [DOT_W-1:0] o_dot
);
   logic signed [PROD_W-1:0] r_px, r_py, r_pz;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_px <= '0;
         r_py <= '0;
         r_pz <= '0;
      end else if (i_en) begin
         r_px <= fmul(i_a.x, i_b.x);
         r_py <= fmul(i_a.y, i_b.y);
         r_pz <= fmul(i_a.z, i_b.z);
      end
   end
   assign o_dot = DOT_W'(r_px) + DOT_W'(r_py) + DOT_W'(r_pz);
endmodule

// File: rtl/shading.sv
// shading: 3-cycle Lambert + sky-ambient shader producing grey RGB888; ports clk, rst_n, bus (shading_if.slave)
module shading
   import shading_pkg::*;
#(
   parameter int                   DATA_WIDTH = 32,
   parameter int                   OUT_WIDTH  = 24,
   parameter logic [OUT_WIDTH-1:0] BG_COLOR   = 24'h000000
) (
   input logic       clk,
   input logic       rst_n,
   shading_if.slave  bus
);
   logic r_v1, r_v2, r_v3, r_h1, r_h2;
   logic signed [DATA_WIDTH+7:0] r_sky1;
   logic [FRAC_BITS:0] r_int2;
   logic [OUT_WIDTH-1:0] r_shade;
   logic signed [DOT_W-1:0] w_dot, w_diff;
   logic signed [DATA_WIDTH+7:0] w_sky;
   logic signed [71:0] w_sum;
   logic [FRAC_BITS:0] w_int;
   logic [8:0] w_ch9;
   logic [7:0] w_ch;
   vec3_dot u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (bus.valid_in),
      .i_a   (bus.normal_vec),
      .i_b   (bus.light_vec),
      .o_dot (w_dot)
   );
   always_comb begin
      w_diff = w_dot < 0 ? '0 : w_dot;
      w_sky  = r_sky1 < 0 ? '0 : r_sky1;
      w_sum  = 72'(AMB_BASE) + 72'(w_sky) + ((72'(w_diff) * 72'(DIFF_K)) >>> FRAC_BITS);
      w_int  = w_sum < 0 ? '0 : w_sum > 72'sd16777216 ? 25'd16777216 : w_sum[FRAC_BITS:0];
      w_ch9  = 9'((33'(r_int2) * 33'd255) >> FRAC_BITS);
      w_ch   = w_ch9 > 9'd255 ? 8'd255 : w_ch9[7:0];
   end
   // data registers load only with their stage valid so outputs hold across bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_h1    <= 1'b0;
         r_h2    <= 1'b0;
         r_sky1  <= '0;
         r_int2  <= '0;
         r_shade <= '0;
      end else begin
         r_v1 <= bus.valid_in;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (bus.valid_in) begin
            r_h1   <= bus.hit_in;
            r_sky1 <= (DATA_WIDTH+8)'(fmul(bus.normal_vec.y, AMB_SKY));
         end
         if (r_v1) begin
            r_h2   <= r_h1;
            r_int2 <= w_int;
         end
         if (r_v2) r_shade <= r_h2 ? OUT_WIDTH'({w_ch, w_ch, w_ch}) : BG_COLOR;
      end
   end
   assign bus.shade_out = r_shade;
   assign bus.valid_out = r_v3;
endmodule

// File: tb/tb_shading.sv
// tb_shading: directed self-checking bench for shading
module tb_shading;
   import shading_pkg::*;
   localparam fp ONE = 32'sh0100_0000;
   localparam fp H = 32'sd11861492;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   shading_if #(.OUT_WIDTH(24)) bus ();
   shading #(.DATA_WIDTH(32), .OUT_WIDTH(24), .BG_COLOR(24'h000000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic h, input vec3 n, input vec3 l);
      bus.valid_in = v;
      bus.hit_in = h;
      bus.normal_vec = n;
      bus.light_vec = l;
   endtask
   task automatic idle();
      drive(1'b0, 1'b0, make_vec3(0, 0, 0), make_vec3(0, 0, 0));
   endtask
   task automatic run1(input string tag, input vec3 n, input vec3 l, input logic h, input logic [23:0] e);
      drive(1'b1, h, n, l);
      step();
      idle();
      step();
      chk({tag, "_lat"}, 32'(bus.valid_out), 32'd0);
      step();
      chk({tag, "_vld"}, 32'(bus.valid_out), 32'd1);
      chk({tag, "_rgb"}, 32'(bus.shade_out), 32'(e));
   endtask
   initial begin
      idle();
      #12;
      chk("rst_vld", 32'(bus.valid_out), 32'd0);
      chk("rst_rgb", 32'(bus.shade_out), 32'd0);
      rst_n = 1'b1;
      step();
      run1("aligned", make_vec3(0, 0, ONE), make_vec3(0, 0, ONE), 1'b1, 24'hE5E5E5);
      run1("opposed", make_vec3(0, 0, ONE), make_vec3(0, 0, -ONE), 1'b1, 24'h191919);
      run1("sky_full", make_vec3(0, ONE, 0), make_vec3(0, 0, ONE), 1'b1, 24'h323232);
      run1("perp", make_vec3(ONE, 0, 0), make_vec3(0, ONE, 0), 1'b1, 24'h191919);
      run1("diag", make_vec3(0, H, H), make_vec3(0, H, H), 1'b1, 24'hF7F7F7);
      run1("clamp_hi", make_vec3(0, 2 * ONE, 0), make_vec3(0, 2 * ONE, 0), 1'b1, 24'hFFFFFF);
      run1("sky_neg", make_vec3(0, -ONE, 0), make_vec3(0, 0, ONE), 1'b1, 24'h191919);
      run1("aligned2", make_vec3(0, 0, ONE), make_vec3(0, 0, ONE), 1'b1, 24'hE5E5E5);
      step();
      chk("hold_vld", 32'(bus.valid_out), 32'd0);
      chk("hold_rgb", 32'(bus.shade_out), 32'hE5E5E5);
      run1("miss", make_vec3(0, 0, ONE), make_vec3(0, 0, ONE), 1'b0, 24'h000000);
      step();
      drive(1'b1, 1'b1, make_vec3(0, 0, ONE), make_vec3(0, 0, ONE));
      step();
      drive(1'b1, 1'b0, make_vec3(0, 0, ONE), make_vec3(0, 0, ONE));
      step();
      chk("b2b_lat", 32'(bus.valid_out), 32'd0);
      drive(1'b1, 1'b1, make_vec3(0, ONE, 0), make_vec3(0, 0, ONE));
      step();
      chk("b2b_a_vld", 32'(bus.valid_out), 32'd1);
      chk("b2b_a_rgb", 32'(bus.shade_out), 32'hE5E5E5);
      drive(1'b1, 1'b1, make_vec3(0, 2 * ONE, 0), make_vec3(0, 2 * ONE, 0));
      step();
      chk("b2b_b_vld", 32'(bus.valid_out), 32'd1);
      chk("b2b_b_rgb", 32'(bus.shade_out), 32'h000000);
      idle();
      step();
      chk("b2b_c_vld", 32'(bus.valid_out), 32'd1);
      chk("b2b_c_rgb", 32'(bus.shade_out), 32'h323232);
      step();
      chk("b2b_d_vld", 32'(bus.valid_out), 32'd1);
      chk("b2b_d_rgb", 32'(bus.shade_out), 32'hFFFFFF);
      step();
      chk("bubble_vld", 32'(bus.valid_out), 32'd0);
      chk("bubble_rgb", 32'(bus.shade_out), 32'hFFFFFF);
      drive(1'b1, 1'b1, make_vec3(0, 0, ONE), make_vec3(0, 0, ONE));
      step();
      drive(1'b1, 1'b1, make_vec3(0, ONE, 0), make_vec3(0, 0, ONE));
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(bus.valid_out), 32'd0);
      chk("arst_rgb", 32'(bus.shade_out), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_idle", 32'(bus.valid_out), 32'd0);
      end
      run1("post_rst", make_vec3(0, 0, ONE), make_vec3(0, 0, ONE), 1'b1, 24'hE5E5E5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
